// File: rtl/addsub_arbiter_if.sv
// addsub_arbiter_if: request/response bundle between requesters and the shared add/sub arbiter
interface addsub_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W = 2
);
    logic [NUM_REQ-1:0]    req;
    logic [16*NUM_REQ-1:0] a_in;
    logic [16*NUM_REQ-1:0] b_in;
    logic [NUM_REQ-1:0]    sub_in;
    logic [NUM_REQ-1:0]    gnt;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [15:0]           result;
    logic                  sat;
    logic                  busy;
    modport master (
        output req, a_in, b_in, sub_in, rsp_ready,
        input  gnt, rsp_valid, rsp_id, result, sat, busy
    );
    modport slave (
        input  req, a_in, b_in, sub_in, rsp_ready,
        output gnt, rsp_valid, rsp_id, result, sat, busy
    );
endinterface

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sharing of one 16-bit saturating add/sub unit among NUM_REQ requesters
module addsub_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum
);
    logic [15:0] bc;
    logic [15:0] raw;
    logic        ovf;
    // two's-complement add of A and (possibly inverted) B, clamped on signed overflow
    always_comb begin
        bc  = sub ? ~b : b;
        raw = a + bc + {15'd0, sub};
        ovf = (~a[15] & ~bc[15] & raw[15]) | (a[15] & bc[15] & ~raw[15]);
        sum = ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : raw;
    end
endmodule

module addsub_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W = 2
) (
    input logic clk,
    input logic rst,
    addsub_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] cand;
    logic            found;
    logic [15:0]     op_a;
    logic [15:0]     op_b;
    logic            op_sub;
    logic [ID_W-1:0] op_id;
    logic [15:0]     bc;
    logic [15:0]     raw;
    logic            sat_c;
    logic [15:0]     sum;

    addsub_16bit u_addsub (
        .a   (op_a),
        .b   (op_b),
        .sub (op_sub),
        .sum (sum)
    );

    // search from ptr upward with wrap; scanning farthest-first leaves the nearest hit in win
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (bus.req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    // saturation flag recomputed from the operand registers with the same rule the unit clamps on
    always_comb begin
        bc    = op_sub ? ~op_b : op_b;
        raw   = op_a + bc + {15'd0, op_sub};
        sat_c = (~op_a[15] & ~bc[15] & raw[15]) | (op_a[15] & bc[15] & ~raw[15]);
    end

    // one-hot grant only in IDLE, suppressed while reset is held; status derived from state
    always_comb begin
        bus.gnt       = (!rst && state == IDLE && found) ? NUM_REQ'(1) << win : '0;
        bus.rsp_valid = state == RESP;
        bus.busy      = state != IDLE;
    end

    // grant -> execute -> respond sequencer; ptr advances past the winner on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_sub     <= 1'b0;
            op_id      <= '0;
            bus.result <= '0;
            bus.rsp_id <= '0;
            bus.sat    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    op_a   <= bus.a_in[int'(win)*16 +: 16];
                    op_b   <= bus.b_in[int'(win)*16 +: 16];
                    op_sub <= bus.sub_in[win];
                    op_id  <= win;
                    state  <= EXEC;
                end
                EXEC: begin
                    bus.result <= sum;
                    bus.rsp_id <= op_id;
                    bus.sat    <= sat_c;
                    state      <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    ptr   <= (int'(op_id) == NUM_REQ - 1) ? '0 : op_id + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: randomized and directed checks of the shared add/sub arbiter against a math model
module tb_addsub_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int ptr_m = 0;
    logic [15:0] opa [4];
    logic [15:0] opb [4];
    logic        ops [4];

    addsub_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

    addsub_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // exact signed arithmetic, then clamp to the 16-bit signed range
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int v = s ? sa - sb : sa + sb;
        if (v > 32767) return {1'b1, 16'h7FFF};
        if (v < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(v)};
    endfunction

    function automatic int model_win(input logic [3:0] m, input int p);
        for (int k = 0; k < 4; k++) if (m[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [15:0] pick();
        logic [15:0] corners [6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h7FFE};
        return ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
    endfunction

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
        opa[i] = a;
        opb[i] = b;
        ops[i] = s;
        bus.a_in[16*i +: 16] = a;
        bus.b_in[16*i +: 16] = b;
        bus.sub_in[i] = s;
    endtask

    task automatic pulse_reset();
        bus.req = '0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        ptr_m = 0;
    endtask

    // one transaction: request, drop req after the grant, hold the response for `hold` cycles, handshake
    task automatic run_txn(input logic [3:0] mask, input int hold, output logic [3:0] g, output int lat,
                           output logic [15:0] res, output logic [1:0] id, output logic s);
        int gc;
        g = '0;
        lat = -1;
        res = 'x;
        id = 'x;
        s = 1'bx;
        bus.req = mask;
        bus.rsp_ready = (hold == 0);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.gnt != 0) break;
        end
        g = bus.gnt;
        gc = cyc;
        @(posedge clk);
        #1 bus.req = '0;
        if (g == 0) return;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        if (!bus.rsp_valid) return;
        lat = cyc - gc;
        res = bus.result;
        id = bus.rsp_id;
        s = bus.sat;
        for (int n = 0; n < hold; n++) begin
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.req = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (bus.gnt !== 4'h0) begin fails++; $display("FAIL reset_gnt got %h exp 0", bus.gnt); end
        tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", bus.rsp_valid); end
        tests++; if (bus.rsp_id !== 2'd0) begin fails++; $display("FAIL reset_id got %0d exp 0", bus.rsp_id); end
        tests++; if (bus.result !== 16'h0) begin fails++; $display("FAIL reset_result got %h exp 0000", bus.result); end
        tests++; if (bus.sat !== 1'b0) begin fails++; $display("FAIL reset_sat got %b exp 0", bus.sat); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        @(posedge clk);
        #1 bus.req = '0;
        rst = 1'b0;
        ptr_m = 0;
    endtask

    task automatic test_directed();
        logic [3:0]  masks [3] = '{4'b0001, 4'b0010, 4'b0100};
        logic [15:0] av [3] = '{16'h0005, 16'h7FFF, 16'h8000};
        logic [15:0] bv [3] = '{16'h0003, 16'h0001, 16'h0001};
        logic        sv [3] = '{1'b1, 1'b0, 1'b1};
        logic [15:0] rv [3] = '{16'h0002, 16'h7FFF, 16'h8000};
        logic        tv [3] = '{1'b0, 1'b1, 1'b1};
        logic [3:0] g;
        int lat;
        logic [15:0] r;
        logic [1:0] id;
        logic s;
        for (int i = 0; i < 3; i++) begin
            set_op(i, av[i], bv[i], sv[i]);
            run_txn(masks[i], 0, g, lat, r, id, s);
            tests++; if (g !== masks[i]) begin fails++; $display("FAIL dir%0d_gnt got %b exp %b", i, g, masks[i]); end
            tests++; if (lat != 2) begin fails++; $display("FAIL dir%0d_latency got %0d exp 2", i, lat); end
            tests++; if (r !== rv[i]) begin fails++; $display("FAIL dir%0d_result got %h exp %h", i, r, rv[i]); end
            tests++; if (s !== tv[i]) begin fails++; $display("FAIL dir%0d_sat got %b exp %b", i, s, tv[i]); end
            tests++; if (id !== 2'(i)) begin fails++; $display("FAIL dir%0d_id got %0d exp %0d", i, id, i); end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] gq [$];
        int gcq [$];
        logic [18:0] rq [$];
        int p = 0;
        int w;
        logic [16:0] e;
        pulse_reset();
        for (int i = 0; i < 4; i++) set_op(i, pick(), pick(), 1'($urandom));
        bus.req = 4'hF;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (bus.gnt != 0) begin
                gq.push_back(bus.gnt);
                gcq.push_back(cyc);
            end
            if (bus.rsp_valid) rq.push_back({bus.rsp_id, bus.sat, bus.result});
        end
        @(posedge clk);
        #1 bus.req = '0;
        repeat (4) @(negedge clk);
        tests++; if (gq.size() != 5) begin fails++; $display("FAIL rr_grant_count got %0d exp 5", gq.size()); end
        tests++; if (rq.size() != 5) begin fails++; $display("FAIL rr_rsp_count got %0d exp 5", rq.size()); end
        for (int k = 0; k < 5 && k < gq.size(); k++) begin
            w = model_win(4'hF, p);
            p = (w + 1) % 4;
            e = model(opa[w], opb[w], ops[w]);
            tests++; if (gq[k] !== 4'(1 << w)) begin fails++; $display("FAIL rr_gnt%0d got %b exp %b", k, gq[k], 4'(1 << w)); end
            if (k > 0) begin
                tests++; if (gcq[k] - gcq[k-1] != 3) begin fails++; $display("FAIL rr_spacing%0d got %0d exp 3", k, gcq[k] - gcq[k-1]); end
            end
            if (k < rq.size()) begin
                tests++; if (rq[k] !== {2'(w), e}) begin fails++; $display("FAIL rr_rsp%0d got %h exp %h", k, rq[k], {2'(w), e}); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [16:0] e;
        logic [15:0] r0;
        logic [1:0] i0;
        logic s0;
        pulse_reset();
        for (int i = 0; i < 4; i++) set_op(i, pick(), pick(), 1'($urandom));
        e = model(opa[0], opb[0], ops[0]);
        bus.rsp_ready = 1'b0;
        bus.req = 4'hF;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.gnt != 0) break;
        end
        tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL bp_first_gnt got %b exp 0001", bus.gnt); end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        tests++; if ({bus.rsp_valid, bus.rsp_id, bus.sat, bus.result} !== {1'b1, 2'd0, e}) begin
            fails++; $display("FAIL bp_rsp got v=%b id=%0d sat/res=%h exp v=1 id=0 sat/res=%h", bus.rsp_valid, bus.rsp_id, {bus.sat, bus.result}, e);
        end
        r0 = bus.result;
        i0 = bus.rsp_id;
        s0 = bus.sat;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++; if ({bus.rsp_valid, bus.result, bus.rsp_id, bus.sat, bus.gnt} !== {1'b1, r0, i0, s0, 4'h0}) begin
                fails++; $display("FAIL bp_hold%0d got %h exp %h", c, {bus.rsp_valid, bus.result, bus.rsp_id, bus.sat, bus.gnt}, {1'b1, r0, i0, s0, 4'h0});
            end
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
        tests++; if (bus.gnt !== 4'h0) begin fails++; $display("FAIL bp_hs_cycle_gnt got %b exp 0000", bus.gnt); end
        @(negedge clk);
        tests++; if (bus.gnt !== 4'b0010) begin fails++; $display("FAIL bp_next_gnt got %b exp 0010", bus.gnt); end
        @(posedge clk);
        #1 bus.req = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_exec();
        logic [3:0] g;
        int lat;
        logic [15:0] r;
        logic [1:0] id;
        logic s;
        int seen = 0;
        logic [16:0] e;
        pulse_reset();
        for (int i = 0; i < 4; i++) set_op(i, pick(), pick(), 1'($urandom));
        run_txn(4'b0010, 0, g, lat, r, id, s);
        bus.req = 4'b0100;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.gnt != 0) break;
        end
        @(posedge clk);
        #1 bus.req = '0;
        #2 rst = 1'b1;
        #1;
        tests++; if ({bus.gnt, bus.rsp_valid, bus.rsp_id, bus.result, bus.sat, bus.busy} !== 25'd0) begin
            fails++; $display("FAIL mid_reset_outputs got %h exp 0", {bus.gnt, bus.rsp_valid, bus.rsp_id, bus.result, bus.sat, bus.busy});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        ptr_m = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL mid_reset_ghost_rsp got %0d exp 0", seen); end
        @(posedge clk);
        #1 set_op(3, pick(), pick(), 1'($urandom));
        e = model(opa[3], opb[3], ops[3]);
        run_txn(4'b1000, 0, g, lat, r, id, s);
        tests++; if (g !== 4'b1000) begin fails++; $display("FAIL post_reset_gnt got %b exp 1000", g); end
        tests++; if ({id, s, r} !== {2'd3, e}) begin fails++; $display("FAIL post_reset_rsp got %h exp %h", {id, s, r}, {2'd3, e}); end
        run_txn(4'b0010, 0, g, lat, r, id, s);
        pulse_reset();
        run_txn(4'b0101, 0, g, lat, r, id, s);
        tests++; if (g !== 4'b0001) begin fails++; $display("FAIL reset_ptr_gnt got %b exp 0001", g); end
        ptr_m = 1;
    endtask

    task automatic test_random();
        logic [3:0] m;
        logic [3:0] g;
        int lat;
        logic [15:0] r;
        logic [1:0] id;
        logic s;
        int w;
        logic [16:0] e;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 4; i++) set_op(i, pick(), pick(), 1'($urandom));
            m = 4'($urandom_range(1, 15));
            w = model_win(m, ptr_m);
            e = model(opa[w], opb[w], ops[w]);
            run_txn(m, $urandom_range(0, 2), g, lat, r, id, s);
            ptr_m = (w + 1) % 4;
            tests++; if (g !== 4'(1 << w)) begin fails++; $display("FAIL rnd%0d_gnt got %b exp %b (req %b)", t, g, 4'(1 << w), m); end
            tests++; if (lat != 2) begin fails++; $display("FAIL rnd%0d_latency got %0d exp 2", t, lat); end
            tests++; if ({id, s, r} !== {2'(w), e}) begin fails++; $display("FAIL rnd%0d_rsp got %h exp %h", t, {id, s, r}, {2'(w), e}); end
        end
    endtask

    initial begin
        bus.req = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.sub_in = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_directed();
        test_round_robin();
        test_backpressure();
        test_reset_mid_exec();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one instance of the team's 16-bit saturating add/sub unit (addsub_16bit) among NUM_REQ requesters, e.g. the ALU path, the PC/branch-target path and the address-generation path.
- Each requester presents two operands and an add/sub select. Requesters are granted round-robin.
- The saturated result, the requester ID and a saturation flag are returned through a valid/ready response interface.
- One transaction is in flight at a time: grant, then execute, then respond.

Parameters:
- NUM_REQ, 4, number of requesters; legal values are 2 to 4.
- ID_W, 2, width of the requester index; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; must be held until the matching gnt bit is seen.
- a_in  in  16*NUM_REQ  operand A for each requester; requester i uses bits [16i+15:16i].
- b_in  in  16*NUM_REQ  operand B for each requester; same packing as a_in.
- sub_in  in  NUM_REQ  per-requester select: 1 = A-B, 0 = A+B.
- gnt  out  NUM_REQ  one-hot grant, pulsed for one cycle; operands are captured on that edge.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- result  out  16  saturated sum or difference.
- sat  out  1  1 = the result was clamped to 0x7FFF or 0x8000.
- busy  out  1  high in EXEC or RESP.

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE and the round-robin pointer ptr goes to 0.
  - gnt=0, rsp_valid=0, rsp_id=0, result=0x0000, sat=0, busy=0.
  - Any in-flight transaction is discarded; no response is issued for it.
- States:
  - IDLE:
    - If req is nonzero, select the winner: the first set req bit found searching from ptr upward, wrapping at NUM_REQ-1 to 0.
    - gnt[winner]=1 combinationally in this cycle.
    - On the edge: latch a, b, sub and winner into internal operand registers, then go to EXEC.
    - If req is 0, gnt=0 and the state holds.
  - EXEC:
    - The shared addsub_16bit instance is driven only from the operand registers.
    - On the edge: capture the unit's Sum into result and the winner into rsp_id, compute sat, then go to RESP.
  - RESP:
    - rsp_valid=1; result, rsp_id and sat are held stable.
    - On an edge with rsp_ready=1: go to IDLE and set ptr = (winner+1) mod NUM_REQ.
    - While rsp_ready=0, the state holds and no grant is issued.
- Latency:
  - Grant cycle G; rsp_valid is first high in cycle G+2.
  - The earliest next grant is in the cycle after the handshake.
  - Maximum throughput is one transaction per 3 cycles.
- sat computation, using the operand registers:
  - Bc = sub ? ~B : B; raw = A + Bc + sub, truncated to 16 bits.
  - sat = (~A[15] & ~Bc[15] & raw[15]) | (A[15] & Bc[15] & ~raw[15]).
  - This matches the clamp condition of addsub_16bit exactly.
- gnt is never asserted outside IDLE and is never multi-hot.
- A req that drops before it is granted is simply not served; no state is kept for it.
- A requester's req still high in the cycle after its grant is treated as a new request. Requesters must drop req on gnt.
- The winner's own req is ignored for the remainder of its transaction.
- Fairness: with all requesters continuously requesting, each is served exactly once per NUM_REQ transactions.
- Widths: all arithmetic is 16-bit with wrap-around internally. The final output is saturated by the shared unit; no carry-out is exposed.

Test Plan:
- Reset release, then req=0001 with a0=0x0005, b0=0x0003, sub0=1:
  - gnt=0001 in cycle G.
  - rsp_valid in G+2 with result=0x0002, sat=0, rsp_id=0.
- req=0010 with a1=0x7FFF, b1=0x0001, sub1=0 -> result=0x7FFF, sat=1, rsp_id=1.
- req=0100 with a2=0x8000, b2=0x0001, sub2=1 -> result=0x8000, sat=1, rsp_id=2.
- req=1111 held continuously, with rsp_ready=1 throughout:
  - grants in order 0001, 0010, 0100, 1000, then 0001.
  - Grants are spaced 3 cycles apart and rsp_id follows 0,1,2,3,0.
- Backpressure: in RESP, hold rsp_ready=0 for 5 cycles with req=1111:
  - result, rsp_id, sat and rsp_valid stay stable.
  - gnt stays 0.
  - The first grant comes in the cycle after rsp_ready=1.
- Assert rst mid-EXEC, then release:
  - All outputs are 0 immediately.
  - No rsp_valid appears for the aborted transaction.
  - The next request from requester 3, with req=1000 only, is granted with ptr=0 search order and returns the correct result.
